mod3_rr_scheduler: RTL and testbench

- Shares one bit-serial mod-3 remainder engine between NREQ requesters.
- Each requester submits a WIDTH-bit word through a valid/ready handshake.
- Round-robin arbitration picks one word, which is fed to the engine MSB-first at one bit per cycle.
- The block returns the final remainder, a divisible-by-3 flag and the requester ID on a valid/ready response port.

---
 rtl/mod3_pkg.sv | 35 +++
 rtl/mod3_rr_scheduler_if.sv | 36 +++
 rtl/mod3_serial_core.sv | 30 +++
 rtl/mod3_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_mod3_rr_scheduler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mod3_pkg.sv
// rtl/mod3_pkg.sv - shared types, constants and remainder step function
//
// Purpose: common definitions for the mod-3 round-robin scheduler.
//   state_t   : scheduler FSM states
//   rem_t     : 2-bit remainder (0..2)
//   mod3_next : one MSB-first step, rem' = (2*rem + bit) mod 3
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic [1:0] rem_t;

  localparam rem_t REM0 = 2'd0;
  localparam rem_t REM1 = 2'd1;
  localparam rem_t REM2 = 2'd2;

  function automatic rem_t mod3_next(rem_t rem, logic bit_in);
    rem_t r;
    case ({rem, bit_in})
      3'b00_0: r = REM0;
      3'b00_1: r = REM1;
      3'b01_0: r = REM2;
      3'b01_1: r = REM0;
      3'b10_0: r = REM1;
      3'b10_1: r = REM2;
      default: r = REM0;  // rem == 3 is unreachable
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mod3_rr_scheduler_if.sv
// rtl/mod3_rr_scheduler_if.sv - request/response bus of the mod-3 scheduler
//
// Purpose: groups the requester and consumer handshakes.
//   req_valid [NREQ]       : per-requester word valid
//   req_data  [NREQ*WIDTH] : requester i at [i*WIDTH +: WIDTH]
//   req_ready [NREQ]       : one-hot accept strobe
//   rsp_valid/rsp_id/rsp_rem/rsp_div : result, held until rsp_ready
//   rsp_ready              : consumer accepts result
// Modports: master = requesters + consumer, slave = scheduler.
interface mod3_rr_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
);
  import mod3_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  rem_t                  rsp_rem;
  logic                  rsp_div;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_rem, rsp_div
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_rem, rsp_div
  );

endinterface

// File: rtl/mod3_serial_core.sv
// rtl/mod3_serial_core.sv - bit-serial mod-3 remainder register
//
// Purpose: accumulates the remainder of an MSB-first bit stream.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : clear remainder to 0 (wins over en)
//   en       : consume bit_in this cycle
//   bit_in   : next bit, MSB first
//   rem      : current remainder
module mod3_serial_core
  import mod3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output rem_t rem
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= REM0;
    end else if (clr) begin
      rem <= REM0;
    end else if (en) begin
      rem <= mod3_next(rem, bit_in);
    end
  end

endmodule

// File: rtl/mod3_rr_scheduler.sv
// rtl/mod3_rr_scheduler.sv - round-robin sharing of one serial mod-3 engine
//
// Purpose: grants one of NREQ requesters round-robin, shifts its word
// MSB-first through the serial core, returns remainder/divisible/id.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : mod3_rr_scheduler_if.slave (request and response handshakes)
module mod3_rr_scheduler
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  mod3_rr_scheduler_if.slave    bus
);

  localparam int CNTW = $clog2(WIDTH + 1);

  state_t            state, state_nx;
  logic [WIDTH-1:0]  sr;
  logic [CNTW-1:0]   cnt;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    rr_ptr;
  rem_t              rsp_rem_q;
  logic              rsp_div_q;

  rem_t              core_rem;
  rem_t              rem_nx;

  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0]   valid_rot;
  logic [IDW:0]      gnt_sum;
  logic [IDW-1:0]    gnt_id;
  logic              gnt_any;
  logic [WIDTH-1:0]  load_word;
  logic              load;
  logic              last_shift;

  // Rotate the valid vector so that rr_ptr lands at bit 0; the lowest set
  // bit of the rotated vector is the grant offset from rr_ptr.
  always_comb begin
    valid_dbl = {bus.req_valid, bus.req_valid};
    valid_rot = NREQ'(valid_dbl >> rr_ptr);
    gnt_any   = 1'b0;
    gnt_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        gnt_any = 1'b1;
        gnt_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
      end
    end
    if (gnt_sum >= (IDW + 1)'(NREQ)) begin
      gnt_sum = gnt_sum - (IDW + 1)'(NREQ);
    end
    gnt_id = gnt_sum[IDW-1:0];
  end

  // Accept strobe only in IDLE and never while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    load_word     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        bus.req_ready[i] = rst && (state == IDLE) && gnt_any;
        load_word        = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load       = (state == IDLE) && gnt_any;
  assign last_shift = (state == SHIFT) && (cnt == CNTW'(1));
  assign rem_nx     = mod3_next(core_rem, sr[WIDTH-1]);

  mod3_serial_core u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .en     (state == SHIFT),
    .bit_in (sr[WIDTH-1]),
    .rem    (core_rem)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any)       state_nx = SHIFT;
      SHIFT:   if (last_shift)    state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr        <= '0;
      cnt       <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
      rsp_rem_q <= REM0;
      rsp_div_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            sr   <= load_word;
            cnt  <= CNTW'(WIDTH);
            id_q <= gnt_id;
          end
        end
        SHIFT: begin
          sr  <= sr << 1;
          cnt <= cnt - CNTW'(1);
          // Capture the final remainder so it is held through RESP.
          if (last_shift) begin
            rsp_rem_q <= rem_nx;
            rsp_div_q <= (rem_nx == REM0);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_rem   = rsp_rem_q;
  assign bus.rsp_div   = rsp_div_q;

endmodule

// File: tb/tb_mod3_rr_scheduler.sv
// tb/tb_mod3_rr_scheduler.sv - directed and random checks of mod3_rr_scheduler
module tb_mod3_rr_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;

  mod3_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  mod3_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, bus.rsp_valid, 1'b1);
  endtask

  task automatic accept_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_word(input int r, input logic [7:0] d, input logic [1:0] exp_rem);
    if (r == 0) begin
      bus.req_data[7:0] = d;
      bus.req_valid     = 2'b01;
    end else begin
      bus.req_data[15:8] = d;
      bus.req_valid      = 2'b10;
    end
    #1;
    check("word_grant", bus.req_ready, (r == 0) ? 2'b01 : 2'b10);
    step();
    bus.req_valid = '0;
    wait_rsp("word_rsp_seen");
    check("word_id", bus.rsp_id, r);
    check("word_rem", bus.rsp_rem, exp_rem);
    check("word_div", bus.rsp_div, exp_rem == 2'd0);
    accept_rsp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_ids  [4];
    logic [1:0] exp_rems [4];
    int         got_n;
    int         m_ptr;
    int         exp_g;
    int         n;
    logic       done;
    logic       rdy;
    logic [1:0] mask;
    logic [7:0] d0, d1, dsel;

    // Reset state
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, 1'b0);
    check("rst_rsp_rem", bus.rsp_rem, 2'd0);
    check("rst_rsp_div", bus.rsp_div, 1'b0);
    do_reset();

    // Single requester, latency WIDTH edges after accept
    bus.req_data  = {8'd0, 8'd9};
    bus.req_valid = 2'b01;
    #1;
    check("single_ready", bus.req_ready, 2'b01);
    step();
    check("single_ready_drop", bus.req_ready, 2'b00);
    bus.req_valid = '0;
    for (int e = 1; e < WIDTH; e++) begin
      step();
      check("single_lat_pre", bus.rsp_valid, 1'b0);
    end
    step();
    check("single_lat_valid", bus.rsp_valid, 1'b1);
    check("single_id", bus.rsp_id, 1'b0);
    check("single_rem", bus.rsp_rem, 2'd0);
    check("single_div", bus.rsp_div, 1'b1);
    accept_rsp();
    check("single_back_idle", bus.rsp_valid, 1'b0);

    // Remainder sweep on requester 1
    run_word(1, 8'd10,  2'd1);
    run_word(1, 8'd128, 2'd2);
    run_word(1, 8'hFF,  2'd0);
    run_word(1, 8'd0,   2'd0);

    // Contention: alternate grants from pointer 0
    do_reset();
    exp_ids  = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_rems = '{2'd2, 2'd1, 2'd2, 2'd1};
    bus.req_data  = {8'd7, 8'd5};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 100 && got_n < 4; c++) begin
      step();
      if (bus.rsp_valid) begin
        check("cont_id", bus.rsp_id, exp_ids[got_n]);
        check("cont_rem", bus.rsp_rem, exp_rems[got_n]);
        got_n++;
      end
    end
    bus.req_valid = '0;
    check("cont_count", got_n, 4);
    step();
    bus.rsp_ready = 1'b0;
    step();

    // Backpressure: pointer is 0, word 4 -> rem 1
    bus.req_data  = {8'd6, 8'd4};
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b11;
    wait_rsp("bp_rsp_seen");
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", bus.rsp_valid, 1'b1);
      check("bp_rem", bus.rsp_rem, 2'd1);
      check("bp_id", bus.rsp_id, 1'b0);
      check("bp_div", bus.rsp_div, 1'b0);
      check("bp_req_ready", bus.req_ready, 2'b00);
    end
    accept_rsp();
    check("bp_next_grant", bus.req_ready, 2'b10);
    bus.req_valid = '0;
    step();
    check("bp_withdraw", bus.rsp_valid, 1'b0);

    // Reset mid-SHIFT
    bus.req_data  = {8'd0, 8'd9};
    bus.req_valid = 2'b10;
    bus.req_data[15:8] = 8'd9;
    step();
    bus.req_valid = '0;
    step();
    step();
    step();
    bus.req_data  = {8'd6, 8'd11};
    bus.req_valid = 2'b11;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_id", bus.rsp_id, 1'b0);
    check("mid_rst_rem", bus.rsp_rem, 2'd0);
    check("mid_rst_div", bus.rsp_div, 1'b0);
    check("mid_rst_ready", bus.req_ready, 2'b00);
    step();
    rst = 1'b1;
    #1;
    check("post_rst_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = '0;
    wait_rsp("post_rst_rsp_seen");
    check("post_rst_id", bus.rsp_id, 1'b0);
    check("post_rst_rem", bus.rsp_rem, 2'd2);
    check("post_rst_div", bus.rsp_div, 1'b0);
    accept_rsp();

    // Random words against a round-robin / remainder model
    do_reset();
    m_ptr = 0;
    for (int w = 0; w < 200; w++) begin
      mask = 2'($urandom_range(1, 3));
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      bus.req_data  = {d1, d0};
      bus.req_valid = mask;
      #1;
      if (((mask >> m_ptr) & 2'b01) != 2'b00) exp_g = m_ptr;
      else exp_g = 1 - m_ptr;
      check("rnd_grant", bus.req_ready, (exp_g == 0) ? 2'b01 : 2'b10);
      step();
      bus.req_valid = '0;
      dsel = (exp_g == 0) ? d0 : d1;
      n    = 0;
      done = 1'b0;
      while (!done && n < 60) begin
        rdy = 1'($urandom_range(0, 1));
        bus.rsp_ready = rdy;
        if (bus.rsp_valid && rdy) begin
          check("rnd_id", bus.rsp_id, exp_g);
          check("rnd_rem", bus.rsp_rem, 32'(dsel) % 3);
          done = 1'b1;
        end
        step();
        n++;
      end
      bus.rsp_ready = 1'b0;
      check("rnd_done", done, 1'b1);
      m_ptr = 1 - exp_g;
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
